// File: rtl/mem_arb_pkg.sv
// Shared types for mem_arbiter: response-state encoding and requester identities.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_RESP = 2'd1,
    D_RESP = 2'd2
  } resp_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_sel_e;

  localparam int MASK_W = 4;

endpackage

// File: rtl/mem_arbiter_arb_pick2.sv
// Two-way grant picker: combinational grants, data wins ties by default; MEM_ARB_RR_EN makes ties alternate.
// All grants are forced low while reset_i is high.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic i_req_i,
  input  logic d_req_i,
  output logic i_gnt_o,
  output logic d_gnt_o
);

  req_sel_e ptr_q, ptr_d;
  logic     contend;

  assign contend = i_req_i & d_req_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= REQ_D;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Only a contested grant hands ownership to the loser.
  always_comb begin
    ptr_d = ptr_q;
    if (contend) begin
      ptr_d = (ptr_q == REQ_D) ? REQ_I : REQ_D;
    end
  end
`else
  always_comb begin
    ptr_d = REQ_D;
  end
`endif

  assign d_gnt_o = !reset_i && d_req_i && (!contend || ptr_q == REQ_D);
  assign i_gnt_o = !reset_i && i_req_i && (!contend || ptr_q == REQ_I);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between fetch and data requesters; grant-to-RVALID is one cycle.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_REQ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [DATA_W-1:0] I_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  input  logic [MASK_W-1:0] D_WMASK,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              M_EN,
  output logic [MASK_W-1:0] M_WE,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [DATA_W-1:0] M_WDATA,
  input  logic [DATA_W-1:0] M_RDATA
);

  logic        i_gnt, d_gnt;
  resp_state_e state_q, state_d;
  logic        store_q, store_d;
  logic        i_rvld, d_rvld;

  arb_pick2 u_pick (
    .clk_i   (CLK),
    .reset_i (RESET),
    .i_req_i (I_REQ),
    .d_req_i (D_REQ),
    .i_gnt_o (i_gnt),
    .d_gnt_o (d_gnt)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    store_d = d_gnt & D_WE;
    if (i_gnt) begin
      state_d = I_RESP;
    end else if (d_gnt) begin
      state_d = D_RESP;
    end
  end

  // RESET masks RVALID directly so a response already in flight is dropped.
  assign i_rvld = !RESET && (state_q == I_RESP);
  assign d_rvld = !RESET && (state_q == D_RESP);

  always_comb begin
    I_GNT    = i_gnt;
    D_GNT    = d_gnt;
    M_EN     = i_gnt | d_gnt;
    M_ADDR   = '0;
    M_WDATA  = '0;
    M_WE     = '0;
    if (d_gnt) begin
      M_ADDR  = D_ADDR;
      M_WDATA = D_WDATA;
      if (D_WE) begin
        M_WE = D_WMASK;
      end
    end else if (i_gnt) begin
      M_ADDR = I_ADDR;
    end
    I_RVALID = i_rvld;
    D_RVALID = d_rvld;
    I_RDATA  = i_rvld ? M_RDATA : '0;
    D_RDATA  = (d_rvld && !store_q) ? M_RDATA : '0;
  end

endmodule
